// File: rtl/axis_unpack.sv
// rtl/axis_unpack.sv - AXI-Stream width down-converter, one WIDTH word to RATIO slices
// Slices leave LSB first; the last slice's handshake can take the next word in the same cycle.
module axis_unpack #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [WIDTH-1:0]       s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [WIDTH/RATIO-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int BW = WIDTH / RATIO;
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic on_last;
  logic in_hs;
  logic out_hs;

  assign on_last       = (idx_q == LAST_IDX);
  assign s_axis_tready = !valid_q || (m_axis_tready && on_last);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = valid_q && m_axis_tready;

  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = valid_q && last_q && on_last;

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IW'(i)) begin
        m_axis_tdata = data_q[i*BW +: BW];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (out_hs) begin
      if (on_last) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // A load either fills an empty holder or replaces the word whose final slice just left.
    if (in_hs) begin
      data_d  = s_axis_tdata;
      last_d  = s_axis_tlast;
      valid_d = 1'b1;
      idx_d   = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_axis_unpack.sv
// tb/tb_axis_unpack.sv - self-checking bench for axis_unpack against a slice-queue model
module tb_axis_unpack;

  localparam int W  = 32;
  localparam int R  = 4;
  localparam int BW = W / R;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [BW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;

  axis_unpack #(.WIDTH(W), .RATIO(R)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } slice_t;

  slice_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic sv, input logic [W-1:0] sd, input logic sl, input logic mr,
                      output logic ihs, output logic ohs,
                      output logic [BW-1:0] odata, output logic olast);
    logic exp_ready;
    @(negedge aclk);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    s_axis_tlast  = sl;
    m_axis_tready = mr;
    #1;
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && mr);
    chk("s_tready", s_axis_tready, exp_ready);
    chk("m_tvalid", m_axis_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("m_tdata", m_axis_tdata, exp_q[0].data);
      chk("m_tlast", m_axis_tlast, exp_q[0].last);
    end
    ohs   = (exp_q.size() != 0) && mr;
    ihs   = sv && exp_ready;
    odata = m_axis_tdata;
    olast = m_axis_tlast;
    if (ohs) void'(exp_q.pop_front());
    if (ihs) begin
      for (int k = 0; k < R; k++) begin
        slice_t s;
        s.data = BW'(sd >> (k * BW));
        s.last = sl && (k == R - 1);
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge aclk);
    #1;
    exp_q.delete();
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
    chk("rst_s_tready", s_axis_tready, 1'b1);
    aresetn = 1'b1;
  endtask

  task automatic drain(output int n_out);
    logic ih, oh, ol;
    logic [BW-1:0] od;
    n_out = 0;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      step(1'b0, '0, 1'b0, 1'b1, ih, oh, od, ol);
      if (oh) n_out++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic          ih, oh, ol;
    logic [BW-1:0] od;
    int            n, cnt, word, pos, hits;
    logic [W-1:0]  words[2];

    do_reset();

    // Single word, LSB slice first, one cycle latency.
    step(1'b1, 32'h44332211, 1'b0, 1'b1, ih, oh, od, ol);
    chk("single_accept", ih, 1'b1);
    drain(n);
    chk("single_slices", n, 4);
    step(1'b0, '0, 1'b0, 1'b1, ih, oh, od, ol);

    // Streaming: ten words back to back, no bubbles.
    word = 0;
    step(1'b1, 32'(word), 1'b0, 1'b1, ih, oh, od, ol);
    if (ih) word++;
    cnt = 0;
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      step(word < 10, 32'(word), 1'b0, 1'b1, ih, oh, od, ol);
      if (oh) cnt++;
      if (s_axis_tready) hits++;
      if (ih) word++;
    end
    chk("stream_slices_40cyc", cnt, 40);
    chk("stream_ready_cycles", hits, 10);
    chk("stream_words", word, 10);

    // Backpressure with random downstream ready.
    words[0] = 32'hDDCCBBAA;
    words[1] = 32'h11223344;
    word = 0;
    cnt = 0;
    for (int c = 0; c < 200 && (word < 2 || exp_q.size() != 0); c++) begin
      step(word < 2, word < 2 ? words[word] : '0, 1'b0, 1'($urandom_range(0, 1)),
           ih, oh, od, ol);
      if (ih && word == 1) chk("bp_reload_on_dd", {oh, od}, {1'b1, 8'hDD});
      if (oh) cnt++;
      if (ih) word++;
    end
    chk("bp_slices", cnt, 8);

    // Packet boundary: tlast only on slice 12.
    word = 0;
    cnt = 0;
    hits = 0;
    pos = 0;
    for (int c = 0; c < 100 && (word < 3 || exp_q.size() != 0); c++) begin
      step(word < 3, 32'hC0DE0000 + 32'(word), word == 2, 1'b1, ih, oh, od, ol);
      if (oh) begin
        cnt++;
        if (ol) begin
          hits++;
          pos = cnt;
        end
      end
      if (ih) word++;
    end
    chk("pkt_tlast_count", hits, 1);
    chk("pkt_tlast_pos", pos, 12);

    // Reset mid-word discards the rest of 0xA5A5A5A5.
    step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, ih, oh, od, ol);
    step(1'b0, '0, 1'b0, 1'b1, ih, oh, od, ol);
    step(1'b0, '0, 1'b0, 1'b1, ih, oh, od, ol);
    do_reset();
    hits = 0;
    cnt = 0;
    word = 0;
    for (int c = 0; c < 20 && (word < 1 || exp_q.size() != 0); c++) begin
      step(word < 1, 32'h01020304, 1'b0, 1'b1, ih, oh, od, ol);
      if (oh) begin
        cnt++;
        if (od == 8'hA5) hits++;
      end
      if (ih) word++;
    end
    chk("rst_no_a5", hits, 0);
    chk("rst_new_slices", cnt, 4);

    // Full downstream stall: second word must wait, then arrive intact.
    words[0] = 32'h87654321;
    words[1] = 32'hFEDCBA98;
    word = 0;
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, words[word], 1'b0, 1'b0, ih, oh, od, ol);
      if (ih) word++;
      if (c > 0 && s_axis_tready) hits++;
    end
    chk("stall_one_accepted", word, 1);
    chk("stall_ready_low", hits, 0);
    cnt = 0;
    for (int c = 0; c < 30 && (word < 2 || exp_q.size() != 0); c++) begin
      step(word < 2, word < 2 ? words[word] : '0, 1'b0, 1'b1, ih, oh, od, ol);
      if (oh) cnt++;
      if (ih) word++;
    end
    chk("stall_slices", cnt, 8);

    // Random traffic on both sides.
    for (int c = 0; c < 2000; c++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), ih, oh, od, ol);
    end
    drain(n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
